// File: rtl/mac_result_drain.sv
// mac_result_drain: snapshots the MAC accumulator vector, drains it row by row with requantization.
// Optional MAC_RESULT_DRAIN_SAT_CNT_EN adds a per-snapshot saturated-lane counter (sat_count).
module mac_result_drain #(
  parameter int MAC_WIDTH   = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5,
  localparam int ROW_W = $clog2(MAC_WIDTH),
  localparam int SAT_W = $clog2(MAC_WIDTH*MAC_WIDTH+1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   acc_valid,
  input  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] acc_data,
  input  logic [SHIFT_WIDTH-1:0]                 shift_amt,
  output logic                                   acc_ready,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [MAC_WIDTH*OUT_WIDTH-1:0]         out_data,
  output logic [ROW_W-1:0]                       out_row,
  output logic                                   out_last,
  output logic                                   busy
`ifdef MAC_RESULT_DRAIN_SAT_CNT_EN
  ,
  output logic [SAT_W-1:0]                       sat_count
`endif
);

  localparam int ROW_BITS = MAC_WIDTH*ACC_WIDTH;
  localparam int LCNT_W   = $clog2(MAC_WIDTH+1);
  localparam logic signed [ACC_WIDTH:0] HI =
    (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] LO = ~HI;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state, state_nx;

  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] snap;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [SHIFT_WIDTH-1:0] shift_cl;
  logic [SHIFT_WIDTH-1:0] shift_sel;
  logic [ROW_W-1:0]       row_nx;
  logic [ROW_BITS-1:0]    row_sel;
  logic [MAC_WIDTH*OUT_WIDTH-1:0] rq_data;
  logic [LCNT_W-1:0]      rq_sat;
  logic [OUT_WIDTH:0]     lane;
  logic cap;
  logic adv;
  logic fin;

  // {saturated, value}: round-half-up shift in ACC_WIDTH+1 bits, then clamp
  function automatic logic [OUT_WIDTH:0] rq_lane(
    input logic [ACC_WIDTH-1:0]   a,
    input logic [SHIFT_WIDTH-1:0] s
  );
    logic signed [ACC_WIDTH:0] x;
    logic [ACC_WIDTH:0] rnd;
    x   = $signed({a[ACC_WIDTH-1], a});
    rnd = '0;
    if (s != '0) begin
      rnd[s - 1'b1] = 1'b1;
      x = (x + $signed(rnd)) >>> s;
    end
    if (x > HI)
      rq_lane = {1'b1, HI[OUT_WIDTH-1:0]};
    else if (x < LO)
      rq_lane = {1'b1, LO[OUT_WIDTH-1:0]};
    else
      rq_lane = {1'b0, x[OUT_WIDTH-1:0]};
  endfunction

  assign acc_ready = (state == IDLE);
  assign busy      = !acc_ready;

  assign shift_cl = (int'(shift_amt) > ACC_WIDTH-1)
                  ? SHIFT_WIDTH'(ACC_WIDTH-1) : shift_amt;

  assign row_nx = out_row + 1'b1;

  // In IDLE row 0 comes straight from the input so it is ready one cycle after capture
  assign row_sel = (state == IDLE)
                 ? acc_data[ROW_BITS-1:0]
                 : snap[row_nx*ROW_BITS +: ROW_BITS];
  assign shift_sel = (state == IDLE) ? shift_cl : shift_q;

  always_comb begin
    rq_data = '0;
    rq_sat  = '0;
    lane    = '0;
    for (int c = 0; c < MAC_WIDTH; c++) begin
      lane = rq_lane(row_sel[c*ACC_WIDTH +: ACC_WIDTH], shift_sel);
      rq_data[c*OUT_WIDTH +: OUT_WIDTH] = lane[OUT_WIDTH-1:0];
      rq_sat = rq_sat + LCNT_W'(lane[OUT_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    adv      = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc_valid) begin
          cap      = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            fin      = 1'b1;
            state_nx = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      shift_q   <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (cap) begin
      snap      <= acc_data;
      shift_q   <= shift_cl;
      out_data  <= rq_data;
      out_row   <= '0;
      out_valid <= 1'b1;
      out_last  <= (MAC_WIDTH == 1);
    end else if (adv) begin
      out_data  <= rq_data;
      out_row   <= row_nx;
      out_last  <= (row_nx == ROW_W'(MAC_WIDTH-1));
    end else if (fin) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef MAC_RESULT_DRAIN_SAT_CNT_EN
  logic [LCNT_W-1:0] beat_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_sat  <= '0;
      sat_count <= '0;
    end else begin
      if (cap || adv)
        beat_sat <= rq_sat;
      if (cap)
        sat_count <= '0;
      else if (adv || fin)
        sat_count <= sat_count + SAT_W'(beat_sat);
    end
  end
`else
  logic unused_sat;
  assign unused_sat = ^rq_sat;
`endif

endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: randomized drain bench checked against an arithmetic reference model.
// Build with MAC_RESULT_DRAIN_SAT_CNT_EN defined to also check sat_count.
module tb_mac_result_drain;

  localparam int MW = 8;
  localparam int AW = 32;
  localparam int OW = 8;
  localparam int SW = 5;
  localparam int RW = 3;
  localparam int LANES = MW*MW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic acc_valid = 1'b0;
  logic [LANES*AW-1:0] acc_data = '0;
  logic [SW-1:0] shift_amt = '0;
  logic acc_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [MW*OW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic out_last;
  logic busy;
`ifdef MAC_RESULT_DRAIN_SAT_CNT_EN
  logic [6:0] sat_count;
`endif

  always #5 clk = ~clk;

  mac_result_drain #(
    .MAC_WIDTH(MW), .ACC_WIDTH(AW),
    .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_valid(acc_valid), .acc_data(acc_data),
    .shift_amt(shift_amt), .acc_ready(acc_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .busy(busy)
`ifdef MAC_RESULT_DRAIN_SAT_CNT_EN
    , .sat_count(sat_count)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int tb_lane[LANES];
  int m_lane[LANES];
  bit m_valid = 0;
  int m_row = 0;
  int m_shift = 0;
  int m_sat = 0;

  function automatic int rq(int v, int s, output bit sat);
    longint r, hi, lo;
    r = v;
    if (s > 0) r = (r + (longint'(1) <<< (s-1))) >>> s;
    hi = (longint'(1) <<< (OW-1)) - 1;
    lo = -hi - 1;
    sat = 0;
    if (r > hi) begin r = hi; sat = 1; end
    else if (r < lo) begin r = lo; sat = 1; end
    return int'(r);
  endfunction

  function automatic logic [MW*OW-1:0] exp_row(int r, output int nsat);
    logic [MW*OW-1:0] res;
    bit s;
    int q;
    res = '0;
    nsat = 0;
    for (int c = 0; c < MW; c++) begin
      q = rq(m_lane[r*MW+c], m_shift, s);
      res[c*OW +: OW] = q[OW-1:0];
      nsat += int'(s);
    end
    return res;
  endfunction

  task automatic load_acc();
    for (int k = 0; k < LANES; k++)
      acc_data[k*AW +: AW] = tb_lane[k];
  endtask

  function automatic int rnd_lane();
    case ($urandom_range(0, 3))
      0: return int'($urandom);
      1: return int'($urandom_range(0, 600)) - 300;
      2: case ($urandom_range(0, 3))
           0: return 32'h7FFF_FFFF;
           1: return 32'h8000_0000;
           2: return 0;
           default: return -1;
         endcase
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  task automatic rand_lanes();
    for (int k = 0; k < LANES; k++) tb_lane[k] = rnd_lane();
    load_acc();
  endtask

  task automatic tick();
    bit cap, hs;
    int ns;
    logic [MW*OW-1:0] er;
    cap = !m_valid && acc_valid;
    hs  = m_valid && out_ready;
    @(posedge clk);
    if (cap) begin
      m_lane  = tb_lane;
      m_shift = (int'(shift_amt) > AW-1) ? AW-1 : int'(shift_amt);
      m_row   = 0;
      m_valid = 1;
      m_sat   = 0;
    end else if (hs) begin
      er = exp_row(m_row, ns);
      m_sat += ns;
      if (m_row == MW-1) m_valid = 0;
      else m_row++;
    end
    #1;
    check("acc_ready", acc_ready, !m_valid);
    check("busy", busy, m_valid);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      er = exp_row(m_row, ns);
      check("out_data", out_data, er);
      check("out_row", out_row, m_row);
      check("out_last", out_last, m_row == MW-1);
    end else begin
      check("out_last_idle", out_last, 0);
    end
`ifdef MAC_RESULT_DRAIN_SAT_CNT_EN
    check("sat_count", sat_count, m_sat);
`endif
  endtask

  task automatic mid_reset();
    #1;
    rst_n = 1'b0;
    #1;
    m_valid = 0;
    m_row = 0;
    m_sat = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_ready", acc_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
`ifdef MAC_RESULT_DRAIN_SAT_CNT_EN
    check("rst_sat_count", sat_count, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // mode 0: ready=1, 1: stall 3 at row 2, 2: random ready,
  // 3: capture attempt at row 4, 4: reset at row 4
  task automatic run(int mode);
    int n, stall;
    bit fired;
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    n = 0;
    stall = 0;
    fired = 0;
    while (m_valid && n < 80) begin
      acc_valid = 1'b0;
      case (mode)
        1: begin
          out_ready = !(m_row == 2 && stall < 3);
          if (!out_ready) stall++;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        3: begin
          out_ready = 1'b1;
          if (m_row == 4 && !fired) begin
            fired = 1;
            rand_lanes();
            shift_amt = 5'd7;
            acc_valid = 1'b1;
          end
        end
        4: begin
          out_ready = 1'b1;
          if (m_row == 4) begin
            mid_reset();
            break;
          end
        end
        default: out_ready = 1'b1;
      endcase
      tick();
      n++;
    end
    acc_valid = 1'b0;
    check("drain_timeout", m_valid, 0);
    if (mode == 0) check("beats_no_bubble", n, MW);
    if (mode == 1) check("beats_stall", n, MW+3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_acc_ready", acc_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_row", out_row, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < LANES; k++) tb_lane[k] = k;
    shift_amt = '0;
    load_acc();
    run(0);

    for (int k = 0; k < LANES; k++) tb_lane[k] = (k % 2) ? -1000 : 1000;
    load_acc();
    run(0);

    for (int k = 0; k < LANES; k++)
      case (k % 4)
        0: tb_lane[k] = 6;
        1: tb_lane[k] = 5;
        2: tb_lane[k] = -6;
        default: tb_lane[k] = -5;
      endcase
    shift_amt = 5'd2;
    load_acc();
    run(2);

    rand_lanes();
    tb_lane[0] = 32'h7FFF_FFFF;
    shift_amt = 5'd31;
    load_acc();
    run(0);

    shift_amt = 5'd3;
    rand_lanes();
    run(1);

    shift_amt = 5'd1;
    rand_lanes();
    run(3);

    rand_lanes();
    run(4);
    shift_amt = 5'd0;
    rand_lanes();
    run(0);

    for (int i = 0; i < 25; i++) begin
      shift_amt = SW'($urandom_range(0, 31));
      rand_lanes();
      run((i % 3 == 0) ? 0 : 2);
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b0;
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Downstream stage of the 8x8 MAC array.
- Snapshots the full accumulator vector when the array flags valid output. Then streams it out one row per beat on a valid/ready interface.
- Each lane is requantized on the way out: arithmetic right shift, round-half-up, saturate to OUT_WIDTH.
- Output feeds the result write-back buffer.

Parameters:
MAC_WIDTH, 8, array dimension; rows drained and lanes per beat
ACC_WIDTH, 32, signed accumulator width per lane
OUT_WIDTH, 8, signed output lane width (8 or 16)
SHIFT_WIDTH, 5, width of shift_amt
ROW_W, $clog2(MAC_WIDTH), width of out_row (localparam)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
acc_valid  in  1  accumulator vector valid (driven from array valid_out)
acc_data  in  MAC_WIDTH*MAC_WIDTH*ACC_WIDTH  accumulators; lane k at [k*ACC_WIDTH +: ACC_WIDTH], k = row*MAC_WIDTH+col
shift_amt  in  SHIFT_WIDTH  requantize right-shift, sampled at capture
acc_ready  out  1  block idle, will accept a capture
out_valid  out  1  out_data holds a valid row
out_ready  in  1  consumer accepts row
out_data  out  MAC_WIDTH*OUT_WIDTH  requantized row; col c at [c*OUT_WIDTH +: OUT_WIDTH]
out_row  out  ROW_W  row index of current beat
out_last  out  1  high with final row (out_row == MAC_WIDTH-1)
busy  out  1  drain in progress (= !acc_ready)

Behaviour:
- Reset values: acc_ready=1, out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, FSM=IDLE, snapshot and shift registers=0.
- FSM states: IDLE, DRAIN.
- IDLE:
  - acc_ready=1.
  - On acc_valid=1: latch acc_data into snapshot and latch shift_amt, clamped to ACC_WIDTH-1 if larger.
  - Load out_data with requantized row 0, set out_row=0, out_valid=1, go to DRAIN.
  - Latency: capture edge to out_valid=1 is 1 cycle.
- DRAIN:
  - acc_ready=0; acc_valid is ignored and no snapshot change occurs.
  - While out_valid && !out_ready: out_data, out_row and out_last hold stable.
  - On out_valid && out_ready with out_row < MAC_WIDTH-1: next cycle out_row+1, out_data = that row, out_valid stays 1. Back-to-back beats carry no bubble.
  - On the handshake with out_row == MAC_WIDTH-1 (out_last=1): next cycle out_valid=0, out_last=0, FSM=IDLE, acc_ready=1.
  - A new capture is possible on the cycle after the final handshake. Minimum period between captures is MAC_WIDTH+1 cycles.
- Requantize, per lane, signed:
  - Sign-extend to ACC_WIDTH+1 bits.
  - If shift s > 0, add 1<<(s-1), then arithmetic right shift by s. If s = 0, the value passes unchanged.
  - Saturate to [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1].
- Reset mid-drain: immediate return to reset values. Remaining rows are discarded; no partial beat follows reset release.
- No combinational path from out_ready to out_valid or out_data. All outputs are registered except acc_ready and busy, which decode FSM state.

Optional Feature:
- Macro MAC_RESULT_DRAIN_SAT_CNT_EN.
- When defined: adds output sat_count (out, 7 bits, counts up to MAC_WIDTH*MAC_WIDTH=64). It counts lanes clamped by saturation in the current snapshot.
  - Cleared to 0 at each capture.
  - Incremented by the number of saturated lanes on each accepted beat.
  - Holds its value in IDLE until the next capture; reset value 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. shift_amt=0, lane k = k (0..63), out_ready=1 -> 8 consecutive beats, one per cycle. Beat r has col c = 8r+c and out_row=r. out_last only on beat 7; acc_ready=1 on the cycle after beat 7.
2. shift_amt=0, lanes alternate +1000 / -1000 -> every beat holds 0x7F, 0x80, ... (127 / -128). With the macro defined, sat_count=64 after the last beat.
3. shift_amt=2, lanes 6, 5, -6, -5 -> outputs 2, 1, -1, -1. shift_amt=31 with lane 0x7FFFFFFF -> 1.
4. Hold out_ready=0 for 3 cycles at beat 2 -> out_data and out_row=2 stable for all 3 cycles. Beat 3 follows the handshake; no beat is skipped or duplicated.
5. Pulse acc_valid with new data during beat 4 -> ignored; rows 5-7 still come from the first snapshot.
6. Assert rst_n=0 for 1 cycle at beat 4 -> out_valid=0 and acc_ready=1 immediately. After release, a fresh capture drains from row 0.
